// File: rtl/blur_frame_scheduler_if.sv
// blur_frame_scheduler_if: requester-side job bus of the blur frame scheduler
//   master: frame sources/sinks (req, kernel_type_*, data_in_*, valid_in)
//   slave : scheduler (grant, ready_in, data_out, valid_out, frame_done, frame_err, underrun)
interface blur_frame_scheduler_if;
  logic [1:0] req, kernel_type_0, kernel_type_1, valid_in;
  logic [1:0] grant, frame_done, frame_err, underrun;
  logic [7:0] data_in_0, data_in_1, data_out;
  logic ready_in, valid_out;
  modport master(
    output req, kernel_type_0, kernel_type_1, data_in_0, data_in_1, valid_in,
    input grant, ready_in, data_out, valid_out, frame_done, frame_err, underrun
  );
  modport slave(
    input req, kernel_type_0, kernel_type_1, data_in_0, data_in_1, valid_in,
    output grant, ready_in, data_out, valid_out, frame_done, frame_err, underrun
  );
endinterface

// File: rtl/blur_frame_scheduler.sv
// blur_frame_scheduler: round-robin sharing of one image_blur engine between two frame requesters
//   clk, reset (sync, active-low)
//   bus    : requester job bus (slave side)
//   busy   : a job is in progress
//   eng_*  : full control of the blur engine (start, kernel, input byte, output byte, done)
module blur_frame_scheduler #(
  parameter int WIDTH = 350,
  parameter int HEIGHT = 350,
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  blur_frame_scheduler_if.slave bus,
  output logic                 busy,
  output logic                 eng_start,
  output logic [1:0]           eng_kernel_type,
  output logic [7:0]           eng_image_in,
  input  logic [7:0]           eng_image_out,
  input  logic                 eng_done
);
  localparam int TOTAL = WIDTH * HEIGHT * 3;
  localparam int CW = $clog2((TOTAL > TIMEOUT ? TOTAL : TIMEOUT) + 1);
  typedef enum logic [2:0] {IDLE, START, LOAD, WAIT_DONE, GAP, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] grant, ur;
  logic last, own, sel, vin, frame_end, time_up;
  logic [7:0] din;
  // owner index follows the one-hot grant; on a tie the requester that did not finish last wins
  assign own = grant[1];
  assign sel = bus.req == 2'b11 ? ~last : bus.req[1];
  assign din = own ? bus.data_in_1 : bus.data_in_0;
  assign vin = bus.valid_in[own];
  assign frame_end = cnt == CW'(TOTAL - 1);
  assign time_up = cnt == CW'(TIMEOUT - 1);
  assign bus.grant = grant;
  assign bus.underrun = ur;
  assign busy = state != IDLE;
  assign eng_start = state == START;
  assign bus.ready_in = state == LOAD;
  assign eng_image_in = state == LOAD && vin ? din : 8'h00;
  assign bus.valid_out = state == DRAIN;
  assign bus.data_out = state == DRAIN ? eng_image_out : 8'h00;
  assign bus.frame_done = state == DRAIN && frame_end ? grant : 2'b00;
  // a done arriving on the timeout cycle takes precedence over the abort
  assign bus.frame_err = state == WAIT_DONE && !eng_done && time_up ? grant : 2'b00;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      grant <= 2'b00;
      ur <= 2'b00;
      eng_kernel_type <= 2'b00;
    end else
      case (state)
        IDLE:
          if (|bus.req) begin
            state <= START;
            grant <= sel ? 2'b10 : 2'b01;
            eng_kernel_type <= sel ? bus.kernel_type_1 : bus.kernel_type_0;
          end
        START: begin
          state <= LOAD;
          cnt <= '0;
        end
        LOAD: begin
          if (!vin) ur[own] <= 1'b1;
          if (frame_end) begin
            state <= WAIT_DONE;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_DONE:
          if (eng_done) state <= GAP;
          else if (time_up) begin
            state <= IDLE;
            last <= own;
            grant <= 2'b00;
          end else cnt <= cnt + 1'b1;
        GAP: begin
          state <= DRAIN;
          cnt <= '0;
        end
        DRAIN:
          if (frame_end) begin
            state <= IDLE;
            last <= own;
            grant <= 2'b00;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_blur_frame_scheduler.sv
// tb_blur_frame_scheduler: table-driven, scoreboarded bench for blur_frame_scheduler with an xor-FF engine model
module tb_blur_frame_scheduler;
  localparam int W = 4, H = 2, TO = 50, TOTAL = W * H * 3;
  typedef struct {
    logic rst;
    logic [1:0] req, k0, k1;
    logic [7:0] base;
    int ur_lo, ur_hi, dly, rst_at, gw, own;
    logic [1:0] kern;
    logic ok;
    logic [1:0] ur;
  } job_t;
  logic clk = 1'b0, reset = 1'b0, busy, eng_start, eng_done;
  logic [1:0] eng_kernel_type;
  logic [7:0] eng_image_in, eng_image_out;
  logic [7:0] mem [TOTAL];
  logic [7:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;
  int in_cnt = 0, dly_cnt = 0, out_k = TOTAL, eng_dly = 5;
  blur_frame_scheduler_if bus();
  blur_frame_scheduler #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .eng_start(eng_start),
    .eng_kernel_type(eng_kernel_type), .eng_image_in(eng_image_in),
    .eng_image_out(eng_image_out), .eng_done(eng_done)
  );
  always #5 clk = ~clk;
  // engine: done pulses eng_dly cycles after the last input byte (never when 0),
  // output byte k appears two cycles after done plus k, inverted
  assign eng_done = dly_cnt == 1;
  assign eng_image_out = (out_k >= 0 && out_k < TOTAL) ? mem[(out_k >= 0 && out_k < TOTAL) ? out_k : 0] ^ 8'hFF : 8'h00;
  always @(posedge clk)
    if (!reset) begin
      dly_cnt <= 0;
      out_k <= TOTAL;
    end else begin
      if (eng_start) in_cnt <= 0;
      if (bus.ready_in && in_cnt < TOTAL) begin
        mem[in_cnt] <= eng_image_in;
        in_cnt <= in_cnt + 1;
        if (in_cnt == TOTAL - 1) dly_cnt <= eng_dly;
      end else if (dly_cnt > 0) dly_cnt <= dly_cnt - 1;
      out_k <= eng_done ? -1 : (out_k < TOTAL ? out_k + 1 : TOTAL);
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " outputs"}, {bus.grant, bus.ready_in, bus.valid_out, bus.data_out, bus.frame_done,
        bus.frame_err, bus.underrun, busy, eng_start, eng_kernel_type, eng_image_in}, 32'h0);
  endtask
  task automatic serve(input job_t j);
    logic [1:0] oh;
    logic [7:0] b;
    logic v;
    int w;
    oh = j.own != 0 ? 2'b10 : 2'b01;
    eng_dly = j.dly;
    bus.kernel_type_0 = j.k0;
    bus.kernel_type_1 = j.k1;
    if (j.rst) begin
      reset = 1'b0;
      @(negedge clk);
      chk_zero("reset");
      reset = 1'b1;
    end
    bus.req = j.req;
    w = 0;
    while (bus.grant == 2'b00 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant wait: got none expected %0h", oh);
      return;
    end
    if (j.gw >= 0) chk("grant latency", w, j.gw);
    chk("grant", bus.grant, oh);
    chk("eng_start", eng_start, 1'b1);
    chk("busy", busy, 1'b1);
    bus.kernel_type_0 = ~j.k0;
    bus.kernel_type_1 = ~j.k1;
    chk("kernel", eng_kernel_type, j.kern);
    for (int i = 0; i < TOTAL; i++) begin
      @(negedge clk);
      b = j.base + 8'(i);
      v = !(i >= j.ur_lo && i <= j.ur_hi);
      bus.data_in_0 = j.own != 0 ? 8'hA5 : b;
      bus.data_in_1 = j.own != 0 ? b : 8'hA5;
      bus.valid_in = j.own != 0 ? {v, 1'b1} : {1'b1, v};
      #1;
      chk("ready_in", bus.ready_in, 1'b1);
      chk("eng_image_in", eng_image_in, v ? b : 8'h00);
      chk("grant hold", bus.grant, oh);
      if (i == 0) chk("start once", eng_start, 1'b0);
      if (i == TOTAL - 1) chk("kernel hold", eng_kernel_type, j.kern);
      exp_q.push_back((v ? b : 8'h00) ^ 8'hFF);
    end
    bus.valid_in = 2'b11;
    @(negedge clk);
    chk("ready_in low", bus.ready_in, 1'b0);
    chk("eng_image_in wait", eng_image_in, 8'h00);
    w = 0;
    while (!bus.valid_out && bus.frame_err == 2'b00 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!j.ok) begin
      chk("timeout latency", w, TO - 1);
      chk("frame_err", bus.frame_err, oh);
      chk("no valid_out", bus.valid_out, 1'b0);
      @(negedge clk);
      chk("busy after err", busy, 1'b0);
      chk("frame_err pulse", bus.frame_err, 2'b00);
      chk("underrun", bus.underrun, j.ur);
      exp_q.delete();
      return;
    end
    chk("first out latency", w, j.dly + 1);
    chk("no frame_err", bus.frame_err, 2'b00);
    for (int i = 0; i < TOTAL; i++) begin
      if (i > 0) @(negedge clk);
      chk("valid_out", bus.valid_out, 1'b1);
      chk("data_out", bus.data_out, exp_q.size() > 0 ? 32'(exp_q.pop_front()) : 32'hDEAD);
      chk("frame_done", bus.frame_done, i == TOTAL - 1 ? oh : 2'b00);
      if (i == j.rst_at) begin
        reset = 1'b0;
        @(negedge clk);
        chk_zero("mid-drain reset");
        reset = 1'b1;
        exp_q.delete();
        return;
      end
    end
    @(negedge clk);
    chk("busy end", busy, 1'b0);
    chk("grant end", bus.grant, 2'b00);
    chk("done pulse", bus.frame_done, 2'b00);
    chk("valid_out end", bus.valid_out, 1'b0);
    chk("underrun", bus.underrun, j.ur);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    job_t t[10];
    t[0] = '{1, 2'b01, 2, 0, 8'h00, -1, -1, 5, -1, 1, 0, 2, 1, 2'b00};
    t[1] = '{1, 2'b11, 1, 3, 8'h40, -1, -1, 5, -1, 1, 0, 1, 1, 2'b00};
    t[2] = '{0, 2'b11, 1, 3, 8'h80, -1, -1, 5, -1, 1, 1, 3, 1, 2'b00};
    t[3] = '{0, 2'b11, 1, 3, 8'hC0, -1, -1, 5, -1, 1, 0, 1, 1, 2'b00};
    t[4] = '{0, 2'b10, 0, 0, 8'h10, 3, 4, 5, -1, 1, 1, 0, 1, 2'b10};
    t[5] = '{0, 2'b01, 3, 0, 8'h20, -1, -1, 0, -1, 1, 0, 3, 0, 2'b10};
    t[6] = '{0, 2'b01, 2, 0, 8'h30, -1, -1, 50, -1, 1, 0, 2, 1, 2'b10};
    t[7] = '{0, 2'b01, 1, 0, 8'h50, -1, -1, 5, 9, 1, 0, 1, 1, 2'b00};
    t[8] = '{0, 2'b01, 2, 0, 8'h60, -1, -1, 5, -1, 1, 0, 2, 1, 2'b00};
    t[9] = '{0, 2'b01, 3, 0, 8'h70, -1, -1, 1, -1, 1, 0, 3, 1, 2'b00};
    bus.req = 2'b00;
    bus.kernel_type_0 = 2'b00;
    bus.kernel_type_1 = 2'b00;
    bus.data_in_0 = 8'h00;
    bus.data_in_1 = 8'h00;
    bus.valid_in = 2'b11;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("power-on reset");
    reset = 1'b1;
    bus.data_in_0 = 8'h5A;
    repeat (2) @(negedge clk);
    chk_zero("idle no req");
    for (int i = 0; i < 10; i++) serve(t[i]);
    bus.req = 2'b00;
    repeat (4) @(negedge clk);
    chk("idle at end busy", busy, 1'b0);
    chk("idle at end grant", bus.grant, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
